// File: rtl/sramlike_pkg.sv
// Shared sram-like bus definitions: size encodings, response payload and
// byte-lane mask helpers. Imported by the responder and by the i/d caches.
package sramlike_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned LANES = DATA_W / 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  // One slot of the response pipe.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } resp_t;

  // Byte-lane enables for a transfer of the given size at the given lane offset.
  function automatic logic [LANES-1:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: byte_mask = 4'b0001 << lane;
      SIZE_HALF: byte_mask = lane[1] ? 4'b1100 : 4'b0011;
      default:   byte_mask = 4'b1111;
    endcase
  endfunction

  // Widen each lane enable to cover its eight data bits.
  function automatic logic [DATA_W-1:0] expand_mask(input logic [LANES-1:0] mask);
    for (int i = 0; i < int'(LANES); i++) begin
      expand_mask[8*i +: 8] = {8{mask[i]}};
    end
  endfunction

endpackage

// File: rtl/sramlike_resp_mem_if.sv
// sram-like bus bundle between an initiator (master) and a responder (slave).
interface sramlike_resp_mem_if;
  import sramlike_pkg::*;

  logic                  req;
  logic                  wr;
  logic [1:0]            size;
  logic [BUS_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  addr_ok;
  logic                  data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );

endinterface

// File: rtl/sramlike_resp_pipe.sv
// Fixed-latency response shift pipe: a push at edge E appears on data_ok/rdata
// in the cycle after edge E+LATENCY-1. Non-read and empty slots carry zero data.
module sramlike_resp_pipe
  import sramlike_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata
);

  resp_t stage_q [LATENCY];
  resp_t head;

  // Slot entering the pipe this cycle; zero data when nothing is pushed.
  always_comb begin
    head       = '0;
    head.valid = push;
    head.data  = push ? push_data : '0;
  end

  // Shift the pipe every cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= head;
      for (int i = 1; i < int'(LATENCY); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_ok = stage_q[LATENCY-1].valid;
  assign rdata   = stage_q[LATENCY-1].data;

endmodule

// File: rtl/sramlike_resp_mem.sv
// sram-like bus responder backed by a word-organised RAM with in-order,
// fixed-latency responses and a cap on outstanding transactions.
// Optional build macro SRAMLIKE_STALL_EN adds LFSR-driven acceptance back-pressure.
module sramlike_resp_mem
  import sramlike_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned LATENCY         = 3,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic               clk,
  input logic               rst,
  sramlike_resp_mem_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_W-1:0]     bit_mask;
  logic [DATA_W-1:0]     push_data;
  logic [CNT_W-1:0]      count_q;
  logic                  resp_ok;
  logic [DATA_W-1:0]     resp_data;
  logic                  slot_free;
  logic                  stall;
  logic                  accept;
  logic                  unused_addr;

  // Upper address bits alias onto the RAM.
  assign idx         = bus.addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^bus.addr[BUS_ADDR_W-1:ADDR_WIDTH+2];
  assign bit_mask    = expand_mask(byte_mask(bus.size, bus.addr[1:0]));

`ifdef SRAMLIKE_STALL_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4, free-running outside reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // A slot is free below the cap, or at the cap when the oldest retires this cycle.
  assign slot_free   = (count_q != CNT_W'(MAX_OUTSTANDING)) | resp_ok;
  assign bus.addr_ok = bus.req & ~rst & slot_free & ~stall;
  assign accept      = bus.req & bus.addr_ok;

  // Reads capture the word as it stands before this edge's update; writes respond with zero.
  assign push_data = bus.wr ? '0 : mem[idx];

  // Masked RAM write at the acceptance edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      mem[idx] <= (mem[idx] & ~bit_mask) | (bus.wdata & bit_mask);
    end
  end

  // Outstanding count: up on accept, down on response, unchanged when both.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept && !resp_ok) begin
      count_q <= count_q + CNT_W'(1);
    end else if (!accept && resp_ok) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  sramlike_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_data),
    .data_ok   (resp_ok),
    .rdata     (resp_data)
  );

  assign bus.data_ok = resp_ok;
  assign bus.rdata   = resp_data;

endmodule

// File: tb/tb_sramlike_resp_mem.sv
// Bench for sramlike_resp_mem: transaction-level reference model (byte-addressed
// word array plus a queue of pending responses tagged with their due cycle).
module tb_sramlike_resp_mem;

  localparam int unsigned AW    = 12;
  localparam int unsigned LAT   = 3;
  localparam int unsigned MAXO  = 2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          GUARD = 64;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sramlike_resp_mem_if bus();

  sramlike_resp_mem #(
    .ADDR_WIDTH      (AW),
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mc       = 0;
  int          obs_cyc;
  logic [31:0] ref_mem [DEPTH];
  pend_t       pend [$];
  logic [7:0]  ref_lfsr = 8'hA5;

  logic        obs_aok, obs_dok, exp_aok, exp_dok;
  logic [31:0] obs_rdata, exp_rdata;

  // One bus cycle: drive after the falling edge, sample 1 time unit later,
  // then advance the reference model to what the next rising edge does.
  task automatic step(input logic r, input logic rq, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd);
    pend_t p;
    int    idx, lo, hi;
    @(negedge clk);
    rst = r; bus.req = rq; bus.wr = w; bus.size = sz; bus.addr = a; bus.wdata = wd;
    #1;
    obs_cyc   = mc;
    obs_aok   = bus.addr_ok;
    obs_dok   = bus.data_ok;
    obs_rdata = bus.rdata;
    exp_dok   = (pend.size() > 0) && (pend[0].due == mc);
    exp_rdata = exp_dok ? pend[0].data : 32'h0;
    exp_aok   = rq && !r && ((pend.size() < int'(MAXO)) || exp_dok);
`ifdef SRAMLIKE_STALL_EN
    exp_aok   = exp_aok && !ref_lfsr[0];
    ref_lfsr  = r ? 8'hA5 : {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
`endif
    if (exp_dok) void'(pend.pop_front());
    if (exp_aok) begin
      idx = int'(a[AW+1:2]);
      if (w) begin
        case (sz)
          2'b00:   begin lo = int'(a[1:0]); hi = lo; end
          2'b01:   begin lo = a[1] ? 2 : 0; hi = lo + 1; end
          default: begin lo = 0; hi = 3; end
        endcase
        for (int b = lo; b <= hi; b++) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        p.data = 32'h0;
      end else begin
        p.data = ref_mem[idx];
      end
      p.due = mc + int'(LAT);
      pend.push_back(p);
    end
    if (r) pend.delete();
    mc++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
      n_checks++;
      if ({obs_aok, obs_dok, obs_rdata} !== {1'b0, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got aok=%b dok=%b rdata=%h want 0 0 00000000",
                 obs_cyc, obs_aok, obs_dok, obs_rdata);
      end
    end
  endtask

  task automatic test_word_write_read();
    logic [31:0] wa [2];
    logic [31:0] want [2];
    logic        iw [2];
    int          ca, g;
    wa[0] = 32'h10; iw[0] = 1'b1; want[0] = 32'h0;
    wa[1] = 32'h10; iw[1] = 1'b0; want[1] = 32'hDEADBEEF;
    for (int t = 0; t < 2; t++) begin
      g = 0;
      do begin
        step(1'b0, 1'b1, iw[t], 2'b10, wa[t], 32'hDEADBEEF);
        g++;
      end while (!obs_aok && g < GUARD);
      ca = obs_cyc;
      n_checks++;
      if (!obs_aok) begin
        n_fail++;
        $display("FAIL word_accept t=%0d got aok=%b want 1", t, obs_aok);
      end
      for (int k = 0; k < int'(LAT) + 1; k++) begin
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        n_checks++;
        if (obs_cyc == ca + int'(LAT)) begin
          if ({obs_dok, obs_rdata} !== {1'b1, want[t]}) begin
            n_fail++;
            $display("FAIL word_resp t=%0d cyc=%0d got dok=%b rdata=%h want 1 %h",
                     t, obs_cyc, obs_dok, obs_rdata, want[t]);
          end
        end else if (obs_dok !== 1'b0) begin
          n_fail++;
          $display("FAIL word_latency t=%0d cyc=%0d got dok=%b want 0", t, obs_cyc, obs_dok);
        end
      end
    end
  endtask

  task automatic test_byte_write();
    logic        rq, w;
    logic [1:0]  sz;
    logic [31:0] a;
    int          ca, g;
    logic        seen;
    for (int t = 0; t < 2; t++) begin
      rq = 1'b1; w = (t == 0); sz = (t == 0) ? 2'b00 : 2'b10; a = (t == 0) ? 32'h13 : 32'h10;
      g = 0;
      do begin
        step(1'b0, rq, w, sz, a, 32'h11223344);
        g++;
      end while (!obs_aok && g < GUARD);
      ca = obs_cyc;
      seen = 1'b0;
      for (int k = 0; k < int'(LAT) + 1; k++) begin
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        n_checks++;
        if ({obs_aok, obs_dok, obs_rdata} !== {exp_aok, exp_dok, exp_rdata}) begin
          n_fail++;
          $display("FAIL byte_model cyc=%0d got aok=%b dok=%b rdata=%h want %b %b %h",
                   obs_cyc, obs_aok, obs_dok, obs_rdata, exp_aok, exp_dok, exp_rdata);
        end
        if (t == 1 && obs_cyc == ca + int'(LAT)) seen = (obs_dok === 1'b1) && (obs_rdata === 32'h11ADBEEF);
      end
      if (t == 1) begin
        n_checks++;
        if (!seen) begin
          n_fail++;
          $display("FAIL byte_merge got rdata=%h want 11adbeef", obs_rdata);
        end
      end
    end
  endtask

  task automatic test_fill();
    int g;
    for (int i = 0; i < 16; i++) begin
      g = 0;
      do begin
        step(1'b0, 1'b1, 1'b1, 2'b10, 32'(i * 4), 32'h5A000000 + 32'(i));
        n_checks++;
        if ({obs_aok, obs_dok, obs_rdata} !== {exp_aok, exp_dok, exp_rdata}) begin
          n_fail++;
          $display("FAIL fill cyc=%0d got aok=%b dok=%b rdata=%h want %b %b %h",
                   obs_cyc, obs_aok, obs_dok, obs_rdata, exp_aok, exp_dok, exp_rdata);
        end
        g++;
      end while (!obs_aok && g < GUARD);
    end
    for (int k = 0; k < int'(LAT) + 1; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      n_checks++;
      if ({obs_aok, obs_dok, obs_rdata} !== {exp_aok, exp_dok, exp_rdata}) begin
        n_fail++;
        $display("FAIL fill_drain cyc=%0d got dok=%b rdata=%h want %b %h",
                 obs_cyc, obs_dok, obs_rdata, exp_dok, exp_rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  aok_pat, dok_pat;
    logic [31:0] rd6;
    int          cur;
    cur = 0; aok_pat = '0; dok_pat = '0; rd6 = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'b10, 32'(cur * 4), 32'h0);
      n_checks++;
      if ({obs_aok, obs_dok, obs_rdata} !== {exp_aok, exp_dok, exp_rdata}) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d got aok=%b dok=%b rdata=%h want %b %b %h",
                 i, obs_aok, obs_dok, obs_rdata, exp_aok, exp_dok, exp_rdata);
      end
      aok_pat[i] = obs_aok;
      dok_pat[i] = obs_dok;
      if (i == 6) rd6 = obs_rdata;
      if (obs_aok) cur++;
    end
`ifndef SRAMLIKE_STALL_EN
    n_checks++;
    if (aok_pat !== 8'b1101_1011) begin
      n_fail++;
      $display("FAIL b2b_addr_ok got pattern=%b want 11011011", aok_pat);
    end
    n_checks++;
    if (dok_pat !== 8'b1101_1000) begin
      n_fail++;
      $display("FAIL b2b_data_ok got pattern=%b want 11011000", dok_pat);
    end
    n_checks++;
    if ({dok_pat[3], aok_pat[3], dok_pat[6], rd6} !== {3'b111, 32'h5A000002}) begin
      n_fail++;
      $display("FAIL full_reuse got dok3=%b aok3=%b dok6=%b rdata6=%h want 1 1 1 5a000002",
               dok_pat[3], aok_pat[3], dok_pat[6], rd6);
    end
`endif
    for (int k = 0; k < int'(LAT) + 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      n_checks++;
      if ({obs_aok, obs_dok, obs_rdata} !== {exp_aok, exp_dok, exp_rdata}) begin
        n_fail++;
        $display("FAIL b2b_drain cyc=%0d got dok=%b rdata=%h want %b %h",
                 obs_cyc, obs_dok, obs_rdata, exp_dok, exp_rdata);
      end
    end
  endtask

  task automatic test_random();
    logic        cr, cw;
    logic [1:0]  cs;
    logic [31:0] ca, cd;
    cr = 1'b0; cw = 1'b0; cs = '0; ca = '0; cd = '0;
    for (int i = 0; i < 300; i++) begin
      if (!cr && $urandom_range(0, 3) != 0) begin
        cr = 1'b1;
        cw = 1'($urandom_range(0, 1));
        cs = 2'($urandom_range(0, 3));
        ca = $urandom();
        ca[AW+1:2] = AW'($urandom_range(0, 15));
        cd = $urandom();
      end
      step(1'b0, cr, cw, cs, ca, cd);
      n_checks++;
      if ({obs_aok, obs_dok, obs_rdata} !== {exp_aok, exp_dok, exp_rdata}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got aok=%b dok=%b rdata=%h want %b %b %h",
                 obs_cyc, obs_aok, obs_dok, obs_rdata, exp_aok, exp_dok, exp_rdata);
      end
      if (cr && obs_aok) cr = 1'b0;
    end
    for (int k = 0; k < int'(LAT) + 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      n_checks++;
      if ({obs_aok, obs_dok, obs_rdata} !== {exp_aok, exp_dok, exp_rdata}) begin
        n_fail++;
        $display("FAIL random_drain cyc=%0d got dok=%b rdata=%h want %b %h",
                 obs_cyc, obs_dok, obs_rdata, exp_dok, exp_rdata);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] a [4];
    logic        w [4];
    int          g, ca;
    logic        seen;
    a[0] = 32'h50; w[0] = 1'b1;
    a[1] = 32'h00; w[1] = 1'b0;
    a[2] = 32'h04; w[2] = 1'b0;
    a[3] = 32'h50; w[3] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      g = 0;
      do begin
        step(1'b0, 1'b1, w[t], 2'b10, a[t], 32'hCAFEF00D);
        g++;
      end while (!obs_aok && g < GUARD);
      if (t == 0) begin
        for (int k = 0; k < int'(LAT) + 1; k++) step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
      n_checks++;
      if ({obs_aok, obs_dok, obs_rdata} !== {1'b0, exp_dok, exp_rdata}) begin
        n_fail++;
        $display("FAIL rst_mid cyc=%0d got aok=%b dok=%b rdata=%h want 0 %b %h",
                 obs_cyc, obs_aok, obs_dok, obs_rdata, exp_dok, exp_rdata);
      end
    end
    for (int k = 0; k < int'(LAT) + 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      n_checks++;
      if ({obs_dok, obs_rdata} !== {1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL rst_dropped cyc=%0d got dok=%b rdata=%h want 0 00000000",
                 obs_cyc, obs_dok, obs_rdata);
      end
    end
    g = 0;
    do begin
      step(1'b0, 1'b1, w[3], 2'b10, a[3], 32'h0);
      g++;
    end while (!obs_aok && g < GUARD);
    ca = obs_cyc;
    seen = 1'b0;
    for (int k = 0; k < int'(LAT) + 1; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      if (obs_cyc == ca + int'(LAT)) seen = (obs_dok === 1'b1) && (obs_rdata === 32'hCAFEF00D);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_keeps_ram got dok=%b rdata=%h want 1 cafef00d", obs_dok, obs_rdata);
    end
  endtask

`ifdef SRAMLIKE_STALL_EN
  task automatic test_stall();
    int cur;
    step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    cur = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'b10, 32'((cur % 16) * 4), 32'h0);
      n_checks++;
      if ({obs_aok, obs_dok, obs_rdata} !== {exp_aok, exp_dok, exp_rdata}) begin
        n_fail++;
        $display("FAIL stall cyc=%0d got aok=%b dok=%b rdata=%h want %b %b %h",
                 obs_cyc, obs_aok, obs_dok, obs_rdata, exp_aok, exp_dok, exp_rdata);
      end
      if (obs_aok) cur++;
    end
  endtask
`endif

  initial begin
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_word_write_read();
    test_byte_write();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_midflight();
`ifdef SRAMLIKE_STALL_EN
    test_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
